// File: rtl/opb_simple_master.sv
// Single-beat OPB bus master: one user command becomes one OPB transfer with retry/timeout handling.
// Define OPB_MASTER_BUSLOCK_EN to hold M_busLock from the first request until completion.
module opb_simple_master #(
    parameter int C_OPB_AWIDTH     = 32,
    parameter int C_OPB_DWIDTH     = 32,
    parameter int C_TIMEOUT_CYCLES = 16,
    parameter int C_MAX_RETRIES    = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
    input  logic [C_OPB_DWIDTH-1:0]   cmd_data,
    input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
    output logic                      rsp_valid,
    output logic [C_OPB_DWIDTH-1:0]   rsp_data,
    output logic [1:0]                rsp_status,
    output logic                      M_request,
    input  logic                      OPB_MGrant,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    output logic                      M_seqAddr,
    output logic                      M_busLock,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_toutSup
);

    localparam int AW = C_OPB_AWIDTH;
    localparam int DW = C_OPB_DWIDTH;
    localparam int BW = C_OPB_DWIDTH / 8;
    localparam int RW = (C_MAX_RETRIES < 1) ? 1 : $clog2(C_MAX_RETRIES + 1);
    localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(C_MAX_RETRIES);
    localparam logic [TW-1:0] TOUT_LAST = TW'(C_TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERRACK  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RETRY   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rnw_q, rnw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [BW-1:0]   be_q, be_d;
    logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
    logic [TW-1:0]   tout_cnt_q, tout_cnt_d;
    logic            done_s;
    logic [1:0]      status_s;
    logic [DW-1:0]   rdata_s;
    logic            lock_s;

    logic            cmd_ready_q, rsp_valid_q, m_request_q, m_select_q, m_rnw_q, m_buslock_q;
    logic [DW-1:0]   rsp_data_q, m_dbus_q;
    logic [1:0]      rsp_status_q;
    logic [AW-1:0]   m_abus_q;
    logic [BW-1:0]   m_be_q;

    // Next-state and completion decode; XFER exit causes are prioritised errAck > xferAck > retry > timeout.
    always_comb begin
        state_d     = state_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        retry_cnt_d = retry_cnt_q;
        tout_cnt_d  = tout_cnt_q;
        done_s      = 1'b0;
        status_s    = ST_OK;
        rdata_s     = {DW{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rnw_d       = cmd_rnw;
                    addr_d      = cmd_addr;
                    data_d      = cmd_data;
                    be_d        = cmd_be;
                    retry_cnt_d = {RW{1'b0}};
                    tout_cnt_d  = {TW{1'b0}};
                    state_d     = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (OPB_MGrant) begin
                    tout_cnt_d = {TW{1'b0}};
                    state_d    = S_XFER;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_XFER: begin
                if (OPB_errAck) begin
                    done_s   = 1'b1;
                    status_s = ST_ERRACK;
                    state_d  = S_IDLE;
                end else if (OPB_xferAck) begin
                    done_s   = 1'b1;
                    status_s = ST_OK;
                    state_d  = S_IDLE;
                    if (rnw_q) begin
                        rdata_s = OPB_DBus;
                    end else begin
                        rdata_s = {DW{1'b0}};
                    end
                end else if (OPB_retry) begin
                    if (retry_cnt_q < RETRY_MAX) begin
                        retry_cnt_d = retry_cnt_q + {{(RW-1){1'b0}}, 1'b1};
                        state_d     = S_REQ;
                    end else begin
                        done_s   = 1'b1;
                        status_s = ST_RETRY;
                        state_d  = S_IDLE;
                    end
                end else if (!OPB_toutSup) begin
                    if (tout_cnt_q == TOUT_LAST) begin
                        done_s   = 1'b1;
                        status_s = ST_TIMEOUT;
                        state_d  = S_IDLE;
                    end else begin
                        tout_cnt_d = tout_cnt_q + {{(TW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    tout_cnt_d = tout_cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef OPB_MASTER_BUSLOCK_EN
    assign lock_s = (state_d != S_IDLE);
`else
    assign lock_s = 1'b0;
`endif

    // State, command latch and registered bus/user outputs derived from the next state.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q      <= S_IDLE;
            rnw_q        <= 1'b0;
            addr_q       <= {AW{1'b0}};
            data_q       <= {DW{1'b0}};
            be_q         <= {BW{1'b0}};
            retry_cnt_q  <= {RW{1'b0}};
            tout_cnt_q   <= {TW{1'b0}};
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= {DW{1'b0}};
            rsp_status_q <= ST_OK;
            m_request_q  <= 1'b0;
            m_select_q   <= 1'b0;
            m_rnw_q      <= 1'b0;
            m_abus_q     <= {AW{1'b0}};
            m_be_q       <= {BW{1'b0}};
            m_dbus_q     <= {DW{1'b0}};
            m_buslock_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            retry_cnt_q <= retry_cnt_d;
            tout_cnt_q  <= tout_cnt_d;
            cmd_ready_q <= (state_d == S_IDLE);
            m_request_q <= (state_d == S_REQ);
            m_select_q  <= (state_d == S_XFER);
            m_buslock_q <= lock_s;
            rsp_valid_q <= done_s;
            // OR-bus rule: every select-qualified output is zero outside XFER.
            if (state_d == S_XFER) begin
                m_rnw_q  <= rnw_d;
                m_abus_q <= addr_d;
                m_be_q   <= be_d;
                m_dbus_q <= rnw_d ? {DW{1'b0}} : data_d;
            end else begin
                m_rnw_q  <= 1'b0;
                m_abus_q <= {AW{1'b0}};
                m_be_q   <= {BW{1'b0}};
                m_dbus_q <= {DW{1'b0}};
            end
            if (done_s) begin
                rsp_data_q   <= rdata_s;
                rsp_status_q <= status_s;
            end else begin
                rsp_data_q   <= rsp_data_q;
                rsp_status_q <= rsp_status_q;
            end
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign M_request  = m_request_q;
    assign M_select   = m_select_q;
    assign M_RNW      = m_rnw_q;
    assign M_ABus     = m_abus_q;
    assign M_BE       = m_be_q;
    assign M_DBus     = m_dbus_q;
    assign M_seqAddr  = 1'b0;
    assign M_busLock  = m_buslock_q;

endmodule

// File: tb/tb_opb_simple_master.sv
// Randomised bench for opb_simple_master: a responsive OPB slave/arbiter plus a transaction-level
// model predicting status, data, latency and phase counts; a monitor checks the bus every cycle.
`timescale 1ns/1ps
module tb_opb_simple_master;
    localparam int T    = 16;
    localparam int MAXR = 4;
`ifdef OPB_MASTER_BUSLOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_TOUT = 3;

    typedef struct {int gd; int nret; int rw; int kind; int w; int s; logic [31:0] sdata;} plan_t;
    typedef struct {logic rnw; logic [31:0] addr; logic [31:0] data; logic [3:0] be; logic [1:0] status;
                    logic [31:0] rdata; int lat; int phases; int reqc; int selc;} exp_t;

    logic OPB_Clk = 1'b0, OPB_Rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_rnw = 1'b0;
    logic [31:0] cmd_addr = 32'h0, cmd_data = 32'h0;
    logic [3:0]  cmd_be = 4'h0;
    logic cmd_ready, rsp_valid, M_request, M_select, M_RNW, M_seqAddr, M_busLock;
    logic [31:0] rsp_data, M_ABus, M_DBus;
    logic [1:0]  rsp_status;
    logic [3:0]  M_BE;
    logic OPB_MGrant = 1'b0, OPB_xferAck = 1'b0, OPB_errAck = 1'b0, OPB_retry = 1'b0, OPB_toutSup = 1'b0;
    logic [31:0] OPB_DBus = 32'h0;

    always #5 OPB_Clk = ~OPB_Clk;

    opb_simple_master #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_TIMEOUT_CYCLES(T), .C_MAX_RETRIES(MAXR)) dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .M_request(M_request), .OPB_MGrant(OPB_MGrant), .M_select(M_select), .M_RNW(M_RNW),
        .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus), .M_seqAddr(M_seqAddr), .M_busLock(M_busLock),
        .OPB_DBus(OPB_DBus), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
        .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup));

    int total = 0, bad = 0;
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Transaction-level expectation from the slave plan.
    function automatic exp_t model(plan_t p, logic rnw, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        exp_t e;
        int att;
        e.rnw = rnw; e.addr = a; e.data = d; e.be = be; e.rdata = 32'h0;
        if (p.nret > MAXR) begin
            att = MAXR + 1; e.status = 2'b11; e.selc = att * (p.rw + 1);
        end else begin
            att = p.nret + 1; e.selc = p.nret * (p.rw + 1);
            case (p.kind)
                K_ACK:   begin e.status = 2'b00; e.selc += p.w + 1; e.rdata = rnw ? p.sdata : 32'h0; end
                K_ERR:   begin e.status = 2'b01; e.selc += p.w + 1; end
                K_BOTH:  begin e.status = 2'b01; e.selc += p.w + 1; end
                default: begin e.status = 2'b10; e.selc += p.s + T; end
            endcase
        end
        e.phases = att;
        e.reqc   = att * (p.gd + 1);
        e.lat    = 1 + e.reqc + e.selc;
        return e;
    endfunction

    plan_t pl;
    exp_t  cur;
    bit    mon_en = 1'b0;

    // Slave/arbiter: reacts just after each rising edge to the master's registered outputs.
    int att = 0, reqn = 0, seln = 0;
    bit selp = 1'b0;
    always begin
        @(posedge OPB_Clk); #1;
        OPB_MGrant = 1'b0; OPB_xferAck = 1'b0; OPB_errAck = 1'b0; OPB_retry = 1'b0;
        OPB_toutSup = 1'b0; OPB_DBus = 32'h0;
        if (!OPB_Rst_n || cmd_ready) begin
            att = 0; reqn = 0; seln = 0; selp = 1'b0;
        end else begin
            if (M_request) begin OPB_MGrant = (reqn == pl.gd); reqn++; end else reqn = 0;
            if (selp && !M_select) att++;
            selp = M_select;
            if (M_select) begin
                seln++;
                if (att < pl.nret) OPB_retry = (seln == pl.rw + 1);
                else begin
                    OPB_toutSup = (seln <= pl.s);
                    if (pl.kind != K_TOUT && seln == pl.w + 1) begin
                        OPB_xferAck = (pl.kind != K_ERR);
                        OPB_errAck  = (pl.kind != K_ACK);
                        OPB_DBus    = (pl.kind == K_ERR) ? 32'h0 : pl.sdata;
                    end
                end
            end else seln = 0;
        end
    end

    // Monitor: per-cycle bus checks and end-of-command comparison with the model.
    bit busy = 1'b0, selm = 1'b0;
    int cyc = 0, ph = 0, rqc = 0, slc = 0, done_cnt = 0;
    int got_lat = 0, got_ph = 0, got_selc = 0, got_reqc = 0;
    logic [1:0]  got_status = 2'b00;
    logic [31:0] got_data = 32'h0, last_data = 32'h0, sel_abus = 32'h0, sel_dbus = 32'h0;
    always @(negedge OPB_Clk) begin
        if (!OPB_Rst_n || !mon_en) begin
            busy = 1'b0; selm = 1'b0; last_data = 32'h0;
        end else begin
            if (busy) cyc++;
            chk("cmd_ready", cmd_ready, !busy || rsp_valid);
            chk("busLock", M_busLock, LOCK_EN && busy && !rsp_valid);
            chk("seqAddr", M_seqAddr, 0);
            chk("req_sel_excl", M_request & M_select, 0);
            if (!busy) chk("idle_req_sel", M_request | M_select, 0);
            if (M_select) begin
                chk("abus", M_ABus, cur.addr);
                chk("be", M_BE, cur.be);
                chk("rnw", M_RNW, cur.rnw);
                chk("dbus", M_DBus, cur.rnw ? 32'h0 : cur.data);
                sel_abus = M_ABus; sel_dbus = M_DBus;
                slc++;
                if (!selm) ph++;
            end else begin
                chk("abus_idle", M_ABus, 0);
                chk("be_idle", M_BE, 0);
                chk("rnw_idle", M_RNW, 0);
                chk("dbus_idle", M_DBus, 0);
            end
            selm = M_select;
            if (M_request) rqc++;
            if (rsp_valid) begin
                chk("rsp_when_busy", busy, 1);
                chk("latency", cyc, cur.lat);
                chk("status", rsp_status, cur.status);
                chk("rdata", rsp_data, cur.rdata);
                chk("phases", ph, cur.phases);
                chk("req_cycles", rqc, cur.reqc);
                chk("sel_cycles", slc, cur.selc);
                got_lat = cyc; got_status = rsp_status; got_data = rsp_data;
                got_ph = ph; got_selc = slc; got_reqc = rqc;
                last_data = rsp_data;
                busy = 1'b0;
                done_cnt++;
            end else begin
                chk("rsp_data_hold", rsp_data, last_data);
            end
            if (cmd_valid && cmd_ready) begin
                busy = 1'b1; cyc = 0; ph = 0; rqc = 0; slc = 0;
            end
        end
    end

    task automatic issue(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input plan_t p);
        int n = 0;
        do begin @(posedge OPB_Clk); #1; n++; end while (!cmd_ready && n < 100);
        chk("ready_wait", cmd_ready, 1);
        pl = p;
        cur = model(p, rnw, a, d, be);
        cmd_rnw = rnw; cmd_addr = a; cmd_data = d; cmd_be = be; cmd_valid = 1'b1;
    endtask

    task automatic finish_cmd();
        int n = 0;
        int start = done_cnt;
        do begin
            @(posedge OPB_Clk); #1; n++;
            if (cmd_ready) cmd_valid = 1'b0;
            else begin
                cmd_valid = 1'($urandom_range(0, 1)); cmd_rnw = 1'($urandom_range(0, 1));
                cmd_addr = $urandom; cmd_data = $urandom; cmd_be = 4'($urandom);
            end
        end while (done_cnt == start && n < 500);
        cmd_valid = 1'b0;
        chk("rsp_arrived", done_cnt - start, 1);
    endtask

    task automatic run(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input plan_t p);
        issue(rnw, a, d, be, p);
        finish_cmd();
    endtask

    initial begin
        plan_t p;
        int d0, n;
        pl = '{gd: 0, nret: 0, rw: 0, kind: K_ACK, w: 0, s: 0, sdata: 32'h0};
        cur = model(pl, 1'b0, 32'h0, 32'h0, 4'h0);
        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req", M_request, 0);
        chk("rst_sel", M_select, 0);
        chk("rst_lock", M_busLock, 0);
        chk("rst_rsp_data", rsp_data, 0);
        @(negedge OPB_Clk); #1 OPB_Rst_n = 1'b1;
        chk("rel_cmd_ready_low", cmd_ready, 0);
        @(posedge OPB_Clk); #1;
        chk("rel_cmd_ready_high", cmd_ready, 1);
        mon_en = 1'b1;

        // Zero-wait write with immediate grant.
        run(1'b0, 32'h0100E100, 32'hDEADBEEF, 4'hF, '{gd: 0, nret: 0, rw: 0, kind: K_ACK, w: 0, s: 0, sdata: 32'h0});
        chk("t1_lat", got_lat, 3);
        chk("t1_status", got_status, 2'b00);
        chk("t1_abus", sel_abus, 32'h0100E100);
        chk("t1_dbus", sel_dbus, 32'hDEADBEEF);

        // Read with three wait states.
        run(1'b1, 32'h0100E104, 32'hFFFFFFFF, 4'hF, '{gd: 0, nret: 0, rw: 0, kind: K_ACK, w: 3, s: 0, sdata: 32'h12345678});
        chk("t2_data", got_data, 32'h12345678);
        chk("t2_lat", got_lat, 6);
        chk("t2_dbus", sel_dbus, 32'h0);

        // Silent slave: timeout after T select cycles.
        run(1'b1, 32'h00000010, 32'h0, 4'h3, '{gd: 0, nret: 0, rw: 0, kind: K_TOUT, w: 0, s: 0, sdata: 32'h0});
        chk("t3_status", got_status, 2'b10);
        chk("t3_selc", got_selc, 16);
        chk("t3_data", got_data, 32'h0);

        // toutSup held 40 cycles, then ack.
        run(1'b1, 32'h00000020, 32'h0, 4'hF, '{gd: 1, nret: 0, rw: 0, kind: K_ACK, w: 44, s: 40, sdata: 32'hCAFE0001});
        chk("t4_status", got_status, 2'b00);
        chk("t4_selc", got_selc, 45);
        chk("t4_data", got_data, 32'hCAFE0001);

        // Five consecutive retries exhaust the budget.
        run(1'b0, 32'h00000030, 32'h55AA55AA, 4'h1, '{gd: 1, nret: 5, rw: 0, kind: K_ACK, w: 0, s: 0, sdata: 32'h0});
        chk("t5_status", got_status, 2'b11);
        chk("t5_phases", got_ph, 5);
        chk("t5_reqc", got_reqc, 10);

        // errAck and xferAck together.
        run(1'b1, 32'h00000040, 32'h0, 4'hF, '{gd: 0, nret: 0, rw: 0, kind: K_BOTH, w: 1, s: 0, sdata: 32'hA5A5A5A5});
        chk("t6_status", got_status, 2'b01);
        chk("t6_data", got_data, 32'h0);

        // Reset during XFER.
        issue(1'b1, 32'h00000050, 32'h0, 4'hF, '{gd: 0, nret: 0, rw: 0, kind: K_TOUT, w: 0, s: 0, sdata: 32'h0});
        d0 = done_cnt;
        n = 0;
        do begin @(posedge OPB_Clk); #1; n++; cmd_valid = 1'b0; end while (!M_select && n < 20);
        chk("t7_reached_xfer", M_select, 1);
        #2 OPB_Rst_n = 1'b0;
        #1;
        chk("t7_sel_async", M_select, 0);
        chk("t7_req_async", M_request, 0);
        chk("t7_lock_async", M_busLock, 0);
        chk("t7_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge OPB_Clk);
        @(negedge OPB_Clk); #1 OPB_Rst_n = 1'b1;
        chk("t7_ready_low", cmd_ready, 0);
        @(posedge OPB_Clk); #1;
        chk("t7_ready_high", cmd_ready, 1);
        chk("t7_rsp_valid_after", rsp_valid, 0);
        repeat (3) @(posedge OPB_Clk);
        chk("t7_no_rsp", done_cnt - d0, 0);

        // Randomised commands.
        for (int i = 0; i < 60; i++) begin
            p.gd    = $urandom_range(0, 2);
            p.nret  = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 6);
            p.kind  = $urandom_range(0, 3);
            p.rw    = (p.kind == K_TOUT) ? 0 : $urandom_range(0, 1);
            p.w     = $urandom_range(0, 5);
            p.s     = $urandom_range(0, 3);
            p.sdata = $urandom;
            run(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
